load_read_unit: RTL
===================

Name: load_read_unit

Overview:
- Data-memory read side of the CPU: accepts one load request from the EX stage and issues a single word-aligned read to data memory.
- Waits a variable number of cycles for the memory response, then extracts the addressed byte, halfword or word.
- Sign- or zero-extends the result and returns it to WB with a one-cycle valid pulse.
- Stalls the pipeline while the access is outstanding; flags misaligned, illegal-size or timed-out accesses as errors.

Parameters:
- ADDR_W, 32, request and memory address width.
- DATA_W, 32, memory data and result width; fixed at 32 by the lane logic.
- TIMEOUT, 15, maximum number of WAIT cycles without mem_rd_valid before an error response.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset; 0 = reset asserted.
- req_valid  in  1  load request present.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  1 = sign-extend, 0 = zero-extend.
- req_ready  out  1  unit idle and able to accept a request.
- mem_rd_en  out  1  memory read strobe, one cycle per access.
- mem_addr  out  ADDR_W  word-aligned read address.
- mem_rd_valid  in  1  read data valid from memory.
- mem_rd_data  in  DATA_W  read data, little-endian.
- rsp_valid  out  1  result pulse, one cycle.
- rsp_data  out  DATA_W  extended load result.
- rsp_err  out  1  error flag, qualified by rsp_valid.
- stall  out  1  pipeline hold.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0, stall=0, timeout counter=0.
  - req_ready=1 once in IDLE.
- Outputs:
  - All outputs are registered, except req_ready and stall, which decode state.
  - req_ready = (state==IDLE).
  - stall = (state==REQ or WAIT).
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: the request is accepted when req_valid=1 (req_ready is 1).
  - Error path, taken if any of:
    - size=11;
    - size=01 and addr[0]=1;
    - size=10 and addr[1:0]!=0.
    In that case, go to RESP with rsp_err=1, rsp_data=0, and do not access memory.
  - Otherwise latch addr/size/signed and go to REQ.
- REQ:
  - mem_rd_en=1 for exactly this cycle.
  - mem_addr = {addr[ADDR_W-1:2], 2'b00}.
  - Go to WAIT with counter=0.
- WAIT:
  - If mem_rd_valid=1: extract the lane, register it into rsp_data with rsp_err=0, and go to RESP.
  - Else if counter==TIMEOUT: rsp_err=1, rsp_data=0, go to RESP.
  - Else counter+1.
  - If mem_rd_valid=1 in the same cycle as counter==TIMEOUT, the data wins (no error).
- RESP: rsp_valid=1 for this cycle only, then go to IDLE. A new request can be accepted the cycle after RESP.
- Lane extraction:
  - byte: selected by addr[1:0]; 00 → bits[7:0], 11 → bits[31:24].
  - half: selected by addr[1]; 0 → [15:0], 1 → [31:16].
  - word: the full 32 bits.
  - Extension: req_signed=1 replicates the MSB of the lane; 0 fills with zeros.
- Latency: accept at cycle N, mem_rd_en at N+1. If mem_rd_valid arrives at N+2, rsp_valid is at N+3. The error path gives rsp_valid at N+1.
- mem_rd_valid outside WAIT is ignored: no state change, no response.
- rsp_data/rsp_err hold their last value between responses and are meaningful only while rsp_valid=1.
- Reset mid-operation: the access is aborted with no rsp_valid, and a late mem_rd_valid after reset release is ignored.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state encoding (2 bits);
  - the TIMEOUT default.
- One combinational sub-module, load_align_ext: inputs word data, addr[1:0], size, signed; output the extended result. It is shared with a future store/load-forwarding path.

Test Plan:
- Word load addr=0x100, signed=0; memory returns 0xDEADBEEF 2 cycles after mem_rd_en → mem_addr=0x100, rsp_data=0xDEADBEEF, rsp_err=0, stall high exactly 3 cycles.
- Byte loads from addr 0x103 with data 0x80xxxxxx → signed gives 0xFFFFFF80, unsigned gives 0x00000080; mem_addr=0x100.
- Half load addr=0x102, data 0x8001xxxx → signed gives 0xFFFF8001; half load addr=0x101 → rsp_err=1 the cycle after acceptance, mem_rd_en never asserted.
- Memory never responds → rsp_valid with rsp_err=1 and rsp_data=0 exactly TIMEOUT+1 WAIT cycles after mem_rd_en; a stray mem_rd_valid afterwards produces no response.
- mem_rd_valid on the timeout cycle → rsp_err=0 with the correct data; then back-to-back requests with req_valid held high → second accepted the cycle after RESP.
- Assert reset during WAIT, then release and drive mem_rd_valid → no rsp_valid, all outputs 0, req_ready=1.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared memory-side definitions for the CPU load/store path:
// access size codes, load unit state encoding and timing defaults.
package cpu_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lru_state_t;

    // Illegal size code or a half/word access not naturally aligned.
    function automatic logic bad_access(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        bad_access = (size == 2'b11)
                  || (size == SZ_HALF && lo[0])
                  || (size == SZ_WORD && lo != 2'b00);
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Picks the addressed byte/halfword/word out of a little-endian
// memory word and sign- or zero-extends it to 32 bits.
module load_align_ext
    import cpu_mem_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = data[{addr_lo, 3'b000} +: 8];
        lane_h = data[{addr_lo[1], 4'b0000} +: 16];
        result = data;
        case (size)
            SZ_BYTE: result = {{24{is_signed & lane_b[7]}}, lane_b};
            SZ_HALF: result = {{16{is_signed & lane_h[15]}}, lane_h};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/load_read_unit.sv
// Data-memory read side: one load at a time, word-aligned memory read,
// bounded wait for the response, lane extract and a one-cycle result.
module load_read_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    output logic              req_ready,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              stall
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    lru_state_t        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [1:0]        addr_lo_q;
    logic [1:0]        size_q;
    logic              sgn_q;
    logic              accept;
    logic              mem_rd_en_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic              rsp_valid_n;
    logic [DATA_W-1:0] rsp_data_n;
    logic              rsp_err_n;
    logic [DATA_W-1:0] lane;

    load_align_ext u_align (
        .data      (mem_rd_data),
        .addr_lo   (addr_lo_q),
        .size      (size_q),
        .is_signed (sgn_q),
        .result    (lane)
    );

    assign req_ready = (state == ST_IDLE);
    assign stall     = (state == ST_REQ) || (state == ST_WAIT);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        accept      = 1'b0;
        mem_rd_en_n = 1'b0;
        mem_addr_n  = mem_addr;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data;
        rsp_err_n   = rsp_err;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (bad_access(req_size, req_addr[1:0])) begin
                        state_n     = ST_RESP;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                        rsp_data_n  = '0;
                    end else begin
                        accept      = 1'b1;
                        state_n     = ST_REQ;
                        mem_rd_en_n = 1'b1;
                        mem_addr_n  = {req_addr[ADDR_W-1:2], 2'b00};
                    end
                end
            end
            ST_REQ: begin
                state_n = ST_WAIT;
                cnt_n   = '0;
            end
            ST_WAIT: begin
                // Data arriving on the last allowed cycle still wins.
                if (mem_rd_valid) begin
                    state_n     = ST_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b0;
                    rsp_data_n  = lane;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    state_n     = ST_RESP;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                    rsp_data_n  = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            addr_lo_q <= '0;
            size_q    <= SZ_BYTE;
            sgn_q     <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            mem_rd_en <= mem_rd_en_n;
            mem_addr  <= mem_addr_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            rsp_err   <= rsp_err_n;
            if (accept) begin
                addr_lo_q <= req_addr[1:0];
                size_q    <= req_size;
                sgn_q     <= req_signed;
            end
        end
    end

endmodule
